pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 32: width of the forwarded stage payload.
REQ-002 Parameter BUBBLE_VAL, default 0: payload value loaded on bubble/flush/reset, PAYLOAD_W bits.
REQ-003 Parameter CTX_W, default 66: width of the multi-cycle context (2-bit step count + 64-bit partial hilo by default).
REQ-004 Parameter STALL_W, default 6: width of the pipeline stall vector.
REQ-005 Parameter STAGE, default 3: stall-vector index of the upstream stage; downstream index is STAGE+1; elaboration SHALL fail if STAGE > STALL_W-2.
REQ-006 Parameter CNT_W, default 8: width of the stall-length counter.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 stall  input  STALL_W  per-stage stop request, 1 = stop.
REQ-010 flush  input  1  pipeline flush (exception/redirect), 1 = kill stage contents.
REQ-011 in_valid  input  1  upstream payload valid.
REQ-012 in_payload  input  PAYLOAD_W  upstream payload.
REQ-013 ctx_i  input  CTX_W  multi-cycle context from upstream execution unit.
REQ-014 out_valid  output  1  registered payload valid.
REQ-015 out_payload  output  PAYLOAD_W  registered payload.
REQ-016 ctx_o  output  CTX_W  registered context returned to upstream unit.
REQ-017 stall_cycles  output  CNT_W  consecutive non-advancing cycles, saturating.
REQ-018 bubble_cnt  output  CNT_W  total bubbles inserted since reset/flush, saturating.

Function
REQ-019 All outputs SHALL be registers updated only on rising clk; no combinational input-to-output path.
REQ-020 Each cycle SHALL select exactly one mode, priority: RESET (rst=1) > FLUSH (flush=1) > ADVANCE (stall[STAGE]=0) > BUBBLE (stall[STAGE]=1, stall[STAGE+1]=0) > HOLD (stall[STAGE]=1, stall[STAGE+1]=1).
REQ-021 ADVANCE: out_payload<=in_payload, out_valid<=in_valid, ctx_o<=0, stall_cycles<=0; regardless of stall[STAGE+1].
REQ-022 BUBBLE: out_payload<=BUBBLE_VAL, out_valid<=0, ctx_o<=ctx_i, stall_cycles<=stall_cycles+1 (saturating), bubble_cnt<=bubble_cnt+1 (saturating).
REQ-023 HOLD: out_payload and out_valid unchanged, ctx_o<=ctx_i, stall_cycles<=stall_cycles+1 (saturating), bubble_cnt unchanged.
REQ-024 FLUSH: out_payload<=BUBBLE_VAL, out_valid<=0, ctx_o<=0, stall_cycles<=0, bubble_cnt<=0; flush overrides any stall combination.
REQ-025 Latency SHALL be exactly one cycle from in_payload to out_payload in ADVANCE.
REQ-026 Saturating counters SHALL stop at 2^CNT_W-1 and never wrap to 0.
REQ-027 stall[] bits other than STAGE and STAGE+1 SHALL have no effect.
REQ-028 in_valid=0 in ADVANCE SHALL still load in_payload verbatim; consumers qualify with out_valid.

Reset
REQ-029 On rst=1 at a rising edge: out_payload=BUBBLE_VAL, out_valid=0, ctx_o=0, stall_cycles=0, bubble_cnt=0, overriding flush and stall.
REQ-030 Reset asserted mid multi-cycle operation (during HOLD/BUBBLE) SHALL discard context; first cycle after deassert behaves per REQ-020 from reset values.

Verification
REQ-031 Defaults; in_payload=0x1234ABCD, in_valid=1, stall=0 -> next edge out_payload=0x1234ABCD, out_valid=1, ctx_o=0, stall_cycles=0.
REQ-032 stall=6'b001000 for 3 cycles, ctx_i=66'h2_00000005_00000007 -> each edge out_valid=0, out_payload=0, ctx_o=ctx_i, stall_cycles 1,2,3, bubble_cnt 1,2,3; then stall=0 -> ctx_o=0, stall_cycles=0.
REQ-033 Load 0xDEADBEEF, then stall=6'b011000 for 4 cycles -> out_payload stays 0xDEADBEEF, out_valid=1, ctx_o tracks ctx_i, bubble_cnt unchanged, stall_cycles=4.
REQ-034 flush=1 with stall=6'b011000 and bubble_cnt=5 -> next edge out_valid=0, out_payload=0, ctx_o=0, stall_cycles=0, bubble_cnt=0.
REQ-035 CNT_W=2, stall=6'b001000 for 6 cycles -> stall_cycles and bubble_cnt reach 3 and stay 3.
REQ-036 rst=1 together with flush=0, stall=0, in_valid=1, in_payload=0xFFFFFFFF -> next edge all outputs at reset values per REQ-029.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// One pipeline boundary register. It forwards a payload and valid bit from an
// upstream stage, and it returns a registered multi-cycle context to the
// upstream execution unit while that unit is stalled. It also keeps two
// saturating counters: the current run of non-advancing cycles, and the
// number of bubbles inserted since the last reset or flush.
//
// Each cycle exactly one mode applies, in this priority order:
//   RESET   rst = 1
//   FLUSH   flush = 1
//   ADVANCE stall[STAGE] = 0
//   BUBBLE  stall[STAGE] = 1, stall[STAGE+1] = 0
//   HOLD    stall[STAGE] = 1, stall[STAGE+1] = 1
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   stall        per-stage stop vector; only bits STAGE and STAGE+1 are used
//   flush        kill stage contents
//   in_valid     upstream payload valid
//   in_payload   upstream payload
//   ctx_i        multi-cycle context from the upstream execution unit
//   out_valid    registered payload valid
//   out_payload  registered payload
//   ctx_o        registered context returned upstream
//   stall_cycles consecutive non-advancing cycles, saturating
//   bubble_cnt   bubbles inserted since reset/flush, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                   PAYLOAD_W  = 32,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0,
    parameter int                   CTX_W      = 66,
    parameter int                   STALL_W    = 6,
    parameter int                   STAGE      = 3,
    parameter int                   CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTX_W-1:0]     ctx_i,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTX_W-1:0]     ctx_o,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // The downstream stall bit must exist in the vector.
    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must be in 0..STALL_W-2");
        end
    endgenerate

    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_FLUSH,
        MODE_ADVANCE,
        MODE_BUBBLE,
        MODE_HOLD
    } mode_t;

    // Counter slots handled by the generate loop below.
    localparam int N_CNT      = 2;
    localparam int CNT_STALL  = 0;
    localparam int CNT_BUBBLE = 1;

    mode_t                      mode;
    logic                       stall_up;
    logic                       stall_dn;

    logic                       valid_reg,   valid_next;
    logic [PAYLOAD_W-1:0]       payload_reg, payload_next;
    logic [CTX_W-1:0]           ctx_reg,     ctx_next;

    logic [N_CNT-1:0]           cnt_clr;
    logic [N_CNT-1:0]           cnt_bump;
    logic [N_CNT-1:0][CNT_W-1:0] cnt_q;

    assign stall_up = stall[STAGE];
    assign stall_dn = stall[STAGE+1];

    // Mode select: one mode per cycle, highest priority first.
    always_comb begin
        mode = MODE_HOLD;
        if (rst)
            mode = MODE_RESET;
        else if (flush)
            mode = MODE_FLUSH;
        else if (!stall_up)
            mode = MODE_ADVANCE;
        else if (!stall_dn)
            mode = MODE_BUBBLE;
        else
            mode = MODE_HOLD;
    end

    // Next-state for payload, valid and context, plus counter controls.
    always_comb begin
        valid_next   = valid_reg;
        payload_next = payload_reg;
        ctx_next     = ctx_reg;
        cnt_clr      = '0;
        cnt_bump     = '0;
        unique case (mode)
            MODE_RESET, MODE_FLUSH: begin
                valid_next   = 1'b0;
                payload_next = BUBBLE_VAL;
                ctx_next     = '0;
                cnt_clr      = '1;
            end
            MODE_ADVANCE: begin
                // Payload loads verbatim even when in_valid is low;
                // consumers qualify it with out_valid.
                valid_next          = in_valid;
                payload_next        = in_payload;
                ctx_next            = '0;
                cnt_clr[CNT_STALL]  = 1'b1;
            end
            MODE_BUBBLE: begin
                valid_next           = 1'b0;
                payload_next         = BUBBLE_VAL;
                ctx_next             = ctx_i;
                cnt_bump[CNT_STALL]  = 1'b1;
                cnt_bump[CNT_BUBBLE] = 1'b1;
            end
            MODE_HOLD: begin
                // Downstream is also stopped: keep the payload in place and
                // only capture the upstream unit's context.
                ctx_next            = ctx_i;
                cnt_bump[CNT_STALL] = 1'b1;
            end
            default: begin
                valid_next   = 1'b0;
                payload_next = BUBBLE_VAL;
                ctx_next     = '0;
                cnt_clr      = '1;
            end
        endcase
    end

    // The mode decode already folds rst in, so the registers just load.
    always_ff @(posedge clk) begin
        valid_reg   <= valid_next;
        payload_reg <= payload_next;
        ctx_reg     <= ctx_next;
    end

    // Saturating counters: clear has priority over increment, and an
    // all-ones value stays put instead of wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] cnt_inc;

            assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_clr[gi])
                    cnt_next = '0;
                else if (cnt_bump[gi])
                    cnt_next = cnt_inc;
            end

            always_ff @(posedge clk) begin
                cnt_reg <= cnt_next;
            end

            assign cnt_q[gi] = cnt_reg;
        end
    endgenerate

    assign out_valid    = valid_reg;
    assign out_payload  = payload_reg;
    assign ctx_o        = ctx_reg;
    assign stall_cycles = cnt_q[CNT_STALL];
    assign bubble_cnt   = cnt_q[CNT_BUBBLE];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed scenarios plus a randomized run checked against a cycle-level
// model of the mode rules. A second instance with CNT_W=2 shares the same
// inputs so counter saturation at 3 can be observed alongside the default
// instance.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [5:0]  stall;
    logic [31:0] in_payload;
    logic [65:0] ctx_i;

    logic        out_valid;
    logic [31:0] out_payload;
    logic [65:0] ctx_o;
    logic [7:0]  stall_cycles;
    logic [7:0]  bubble_cnt;

    logic        s_valid;
    logic [31:0] s_payload;
    logic [65:0] s_ctx;
    logic [1:0]  s_stall_cycles;
    logic [1:0]  s_bubble_cnt;

    int total = 0;
    int bad   = 0;

    // Model state
    logic        m_valid;
    logic [31:0] m_payload;
    logic [65:0] m_ctx;
    int          m_sc, m_bc, m_sc_s, m_bc_s;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .ctx_i(ctx_i),
        .out_valid(out_valid), .out_payload(out_payload), .ctx_o(ctx_o),
        .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .ctx_i(ctx_i),
        .out_valid(s_valid), .out_payload(s_payload), .ctx_o(s_ctx),
        .stall_cycles(s_stall_cycles), .bubble_cnt(s_bubble_cnt)
    );

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic [65:0] rand_ctx();
        return {2'($urandom), $urandom, $urandom};
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then move 1ns past the edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (rst || flush) begin
            m_valid = 1'b0; m_payload = '0; m_ctx = '0;
            m_sc = 0; m_bc = 0; m_sc_s = 0; m_bc_s = 0;
        end else if (!stall[3]) begin
            m_payload = in_payload; m_valid = in_valid; m_ctx = '0;
            m_sc = 0; m_sc_s = 0;
        end else begin
            m_ctx  = ctx_i;
            m_sc   = sat(m_sc + 1, 255);
            m_sc_s = sat(m_sc_s + 1, 3);
            if (!stall[4]) begin
                m_payload = '0; m_valid = 1'b0;
                m_bc   = sat(m_bc + 1, 255);
                m_bc_s = sat(m_bc_s + 1, 3);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b1;
        in_payload = 32'hFFFF_FFFF; ctx_i = rand_ctx();
        tick();
        $display("reset: valid=%0b payload=%h ctx=%h sc=%0d bc=%0d", out_valid, out_payload, ctx_o, stall_cycles, bubble_cnt);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_payload !== 32'h0) begin bad++; $display("FAIL reset_payload got=%h want=0", out_payload); end
        total++; if (ctx_o !== 66'h0) begin bad++; $display("FAIL reset_ctx got=%h want=0", ctx_o); end
        total++; if (stall_cycles !== 8'd0) begin bad++; $display("FAIL reset_sc got=%0d want=0", stall_cycles); end
        total++; if (bubble_cnt !== 8'd0) begin bad++; $display("FAIL reset_bc got=%0d want=0", bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_advance();
        logic [31:0] r;
        in_valid = 1'b1; in_payload = 32'h1234_ABCD; stall = '0; ctx_i = rand_ctx();
        tick();
        $display("advance: valid=%0b payload=%h ctx=%h sc=%0d", out_valid, out_payload, ctx_o, stall_cycles);
        total++; if (out_payload !== 32'h1234_ABCD) begin bad++; $display("FAIL adv_payload got=%h want=1234abcd", out_payload); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL adv_valid got=%0b want=1", out_valid); end
        total++; if (ctx_o !== 66'h0) begin bad++; $display("FAIL adv_ctx got=%h want=0", ctx_o); end
        total++; if (stall_cycles !== 8'd0) begin bad++; $display("FAIL adv_sc got=%0d want=0", stall_cycles); end
        // Invalid payload is still loaded verbatim; other stall bits ignored.
        r = $urandom; in_valid = 1'b0; in_payload = r; stall = 6'b100111;
        tick();
        $display("advance_invalid: valid=%0b payload=%h", out_valid, out_payload);
        total++; if (out_payload !== r) begin bad++; $display("FAIL adv_inv_payload got=%h want=%h", out_payload, r); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL adv_inv_valid got=%0b want=0", out_valid); end
        stall = '0;
    endtask

    task automatic test_bubble();
        stall = 6'b001000; ctx_i = 66'h2_00000005_00000007; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_payload = $urandom;
            tick();
            $display("bubble %0d: valid=%0b payload=%h ctx=%h sc=%0d bc=%0d", i, out_valid, out_payload, ctx_o, stall_cycles, bubble_cnt);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bub_valid got=%0b want=0", out_valid); end
            total++; if (out_payload !== 32'h0) begin bad++; $display("FAIL bub_payload got=%h want=0", out_payload); end
            total++; if (ctx_o !== 66'h2_00000005_00000007) begin bad++; $display("FAIL bub_ctx got=%h want=2_00000005_00000007", ctx_o); end
            total++; if (stall_cycles !== 8'(i + 1)) begin bad++; $display("FAIL bub_sc got=%0d want=%0d", stall_cycles, i + 1); end
            total++; if (bubble_cnt !== 8'(i + 1)) begin bad++; $display("FAIL bub_bc got=%0d want=%0d", bubble_cnt, i + 1); end
        end
        stall = '0;
        tick();
        $display("bubble_release: ctx=%h sc=%0d bc=%0d", ctx_o, stall_cycles, bubble_cnt);
        total++; if (ctx_o !== 66'h0) begin bad++; $display("FAIL bub_rel_ctx got=%h want=0", ctx_o); end
        total++; if (stall_cycles !== 8'd0) begin bad++; $display("FAIL bub_rel_sc got=%0d want=0", stall_cycles); end
        total++; if (bubble_cnt !== 8'd3) begin bad++; $display("FAIL bub_rel_bc got=%0d want=3", bubble_cnt); end
    endtask

    task automatic test_hold();
        logic [65:0] c;
        stall = '0; in_valid = 1'b1; in_payload = 32'hDEAD_BEEF;
        tick();
        stall = 6'b011000;
        for (int i = 0; i < 4; i++) begin
            c = rand_ctx(); ctx_i = c; in_payload = $urandom; in_valid = 1'($urandom);
            tick();
            $display("hold %0d: valid=%0b payload=%h ctx=%h sc=%0d bc=%0d", i, out_valid, out_payload, ctx_o, stall_cycles, bubble_cnt);
            total++; if (out_payload !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold_payload got=%h want=deadbeef", out_payload); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0b want=1", out_valid); end
            total++; if (ctx_o !== c) begin bad++; $display("FAIL hold_ctx got=%h want=%h", ctx_o, c); end
            total++; if (bubble_cnt !== 8'd3) begin bad++; $display("FAIL hold_bc got=%0d want=3", bubble_cnt); end
            total++; if (stall_cycles !== 8'(i + 1)) begin bad++; $display("FAIL hold_sc got=%0d want=%0d", stall_cycles, i + 1); end
        end
    endtask

    task automatic test_flush();
        stall = 6'b001000;
        tick();
        tick();
        total++; if (bubble_cnt !== 8'd5) begin bad++; $display("FAIL flush_pre_bc got=%0d want=5", bubble_cnt); end
        flush = 1'b1; stall = 6'b011000; ctx_i = rand_ctx(); in_valid = 1'b1; in_payload = $urandom;
        tick();
        $display("flush: valid=%0b payload=%h ctx=%h sc=%0d bc=%0d", out_valid, out_payload, ctx_o, stall_cycles, bubble_cnt);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
        total++; if (out_payload !== 32'h0) begin bad++; $display("FAIL flush_payload got=%h want=0", out_payload); end
        total++; if (ctx_o !== 66'h0) begin bad++; $display("FAIL flush_ctx got=%h want=0", ctx_o); end
        total++; if (stall_cycles !== 8'd0) begin bad++; $display("FAIL flush_sc got=%0d want=0", stall_cycles); end
        total++; if (bubble_cnt !== 8'd0) begin bad++; $display("FAIL flush_bc got=%0d want=0", bubble_cnt); end
        flush = 1'b0; stall = '0;
    endtask

    task automatic test_saturation();
        rst = 1'b1; tick(); rst = 1'b0;
        stall = 6'b001000;
        for (int i = 0; i < 260; i++) begin
            ctx_i = rand_ctx();
            tick();
            if (i < 6 || i >= 253)
                $display("sat %0d: sc=%0d bc=%0d small_sc=%0d small_bc=%0d", i, stall_cycles, bubble_cnt, s_stall_cycles, s_bubble_cnt);
            total++; if (s_stall_cycles !== 2'(sat(i + 1, 3))) begin bad++; $display("FAIL sat_small_sc cyc=%0d got=%0d want=%0d", i, s_stall_cycles, sat(i + 1, 3)); end
            total++; if (s_bubble_cnt !== 2'(sat(i + 1, 3))) begin bad++; $display("FAIL sat_small_bc cyc=%0d got=%0d want=%0d", i, s_bubble_cnt, sat(i + 1, 3)); end
            total++; if (stall_cycles !== 8'(sat(i + 1, 255))) begin bad++; $display("FAIL sat_sc cyc=%0d got=%0d want=%0d", i, stall_cycles, sat(i + 1, 255)); end
            total++; if (bubble_cnt !== 8'(sat(i + 1, 255))) begin bad++; $display("FAIL sat_bc cyc=%0d got=%0d want=%0d", i, bubble_cnt, sat(i + 1, 255)); end
        end
        stall = '0;
    endtask

    task automatic test_reset_mid_hold();
        logic [65:0] c;
        stall = '0; in_valid = 1'b1; in_payload = 32'hCAFE_F00D;
        tick();
        stall = 6'b011000;
        tick();
        tick();
        rst = 1'b1; flush = 1'b1; ctx_i = rand_ctx();
        tick();
        rst = 1'b0; flush = 1'b0;
        $display("reset_mid_hold: valid=%0b payload=%h ctx=%h sc=%0d", out_valid, out_payload, ctx_o, stall_cycles);
        total++; if (out_payload !== 32'h0) begin bad++; $display("FAIL rmh_payload got=%h want=0", out_payload); end
        total++; if (stall_cycles !== 8'd0) begin bad++; $display("FAIL rmh_sc got=%0d want=0", stall_cycles); end
        c = rand_ctx(); ctx_i = c;
        tick();
        $display("after_reset_hold: valid=%0b payload=%h ctx=%h sc=%0d bc=%0d", out_valid, out_payload, ctx_o, stall_cycles, bubble_cnt);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arh_valid got=%0b want=0", out_valid); end
        total++; if (out_payload !== 32'h0) begin bad++; $display("FAIL arh_payload got=%h want=0", out_payload); end
        total++; if (ctx_o !== c) begin bad++; $display("FAIL arh_ctx got=%h want=%h", ctx_o, c); end
        total++; if (stall_cycles !== 8'd1) begin bad++; $display("FAIL arh_sc got=%0d want=1", stall_cycles); end
        total++; if (bubble_cnt !== 8'd0) begin bad++; $display("FAIL arh_bc got=%0d want=0", bubble_cnt); end
        stall = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 31) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            stall      = 6'($urandom);
            in_valid   = 1'($urandom);
            in_payload = $urandom;
            ctx_i      = rand_ctx();
            tick();
            $display("rnd %0d: rst=%0b fl=%0b st=%b v=%0b p=%h sc=%0d bc=%0d", i, rst, flush, stall, out_valid, out_payload, stall_cycles, bubble_cnt);
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, out_valid, m_valid); end
            total++; if (out_payload !== m_payload) begin bad++; $display("FAIL rnd_payload cyc=%0d got=%h want=%h", i, out_payload, m_payload); end
            total++; if (ctx_o !== m_ctx) begin bad++; $display("FAIL rnd_ctx cyc=%0d got=%h want=%h", i, ctx_o, m_ctx); end
            total++; if (stall_cycles !== 8'(m_sc)) begin bad++; $display("FAIL rnd_sc cyc=%0d got=%0d want=%0d", i, stall_cycles, m_sc); end
            total++; if (bubble_cnt !== 8'(m_bc)) begin bad++; $display("FAIL rnd_bc cyc=%0d got=%0d want=%0d", i, bubble_cnt, m_bc); end
            total++; if (s_stall_cycles !== 2'(m_sc_s)) begin bad++; $display("FAIL rnd_small_sc cyc=%0d got=%0d want=%0d", i, s_stall_cycles, m_sc_s); end
            total++; if (s_bubble_cnt !== 2'(m_bc_s)) begin bad++; $display("FAIL rnd_small_bc cyc=%0d got=%0d want=%0d", i, s_bubble_cnt, m_bc_s); end
            total++; if (s_payload !== m_payload) begin bad++; $display("FAIL rnd_small_payload cyc=%0d got=%h want=%h", i, s_payload, m_payload); end
        end
        rst = 1'b0; flush = 1'b0; stall = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0;
        in_payload = '0; ctx_i = '0;
        m_valid = 1'b0; m_payload = '0; m_ctx = '0;
        m_sc = 0; m_bc = 0; m_sc_s = 0; m_bc_s = 0;
        #1;
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_saturation();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
